// File: rtl/wb_stage_pkg.sv
// Shared widths, load-size and FSM encodings for the write-back stage.
package wb_stage_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 5;
    localparam int WB_ZR_IDX = 31;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_PAIR = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_ld_extract.sv
// Load-data lane extraction with zero/sign extension from a 64-bit read word.
// Address bits below the access size are ignored (no misalignment handling).
module ld_extract
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [2:0]        addr_lo_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;
    logic [31:0] word_f;

    assign byte_f = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_f = rdata_i[{addr_lo_i[2:1], 4'b0000} +: 16];
    assign word_f = rdata_i[{addr_lo_i[2], 5'b00000} +: 32];

    always_comb begin
        data_o = rdata_i;
        case (ld_size_e'(size_i))
            LD_B: data_o = {{(DATA_W-8){signed_i & byte_f[7]}}, byte_f};
            LD_H: data_o = {{(DATA_W-16){signed_i & half_f[15]}}, half_f};
            LD_W: data_o = {{(DATA_W-32){signed_i & word_f[31]}}, word_f};
            LD_D: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers MEM results, drives the register-file write port and
// serialises load-pair writes over two cycles. WB_STAGE_PERF_CNT_EN adds a commit counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int ZR_IDX = WB_ZR_IDX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              mem_valid_i,
    input  logic              mem_wreg_i,
    input  logic [ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              mem_is_load_i,
    input  logic [1:0]        mem_ld_size_i,
    input  logic              mem_ld_signed_i,
    input  logic [2:0]        mem_addr_lo_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_wreg2_i,
    input  logic [ADDR_W-1:0] mem_wd2_i,
    input  logic [DATA_W-1:0] mem_wdata2_i,
    output logic              stallreq_o,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [31:0]       wb_cnt_o
);

    localparam logic [ADDR_W-1:0] ZR_ADDR = ADDR_W'(ZR_IDX);

    wb_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [DATA_W-1:0] ld_data;

    ld_extract #(
        .DATA_W(DATA_W)
    ) u_ld_extract (
        .size_i   (mem_ld_size_i),
        .signed_i (mem_ld_signed_i),
        .addr_lo_i(mem_addr_lo_i),
        .rdata_i  (mem_rdata_i),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = WriteDisable;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (flush_i) begin
            state_d     = WB_IDLE;
            pend_addr_d = '0;
            pend_data_d = '0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (mem_valid_i) begin
                        we_d    = (mem_wreg_i && (mem_wd_i != ZR_ADDR)) ? WriteEnable : WriteDisable;
                        waddr_d = mem_wd_i;
                        wdata_d = mem_is_load_i ? ld_data : mem_wdata_i;
                        if (mem_wreg2_i) begin
                            pend_addr_d = mem_wd2_i;
                            pend_data_d = mem_wdata2_i;
                            state_d     = WB_PAIR;
                        end
                    end
                end
                // MEM inputs are held by the stall here, so only pending values matter.
                WB_PAIR: begin
                    we_d    = (pend_addr_q != ZR_ADDR) ? WriteEnable : WriteDisable;
                    waddr_d = pend_addr_q;
                    wdata_d = pend_data_q;
                    state_d = WB_IDLE;
                end
                default: state_d = WB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= WB_IDLE;
            we_q        <= WriteDisable;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign stallreq_o = (state_q == WB_PAIR);
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;

`ifdef WB_STAGE_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Counts writes already sitting in the output register, i.e. committed ones.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else if (we_q) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign wb_cnt_o = cnt_q;
`else
    assign wb_cnt_o = '0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage sitting directly upstream of the 64-bit, 32-entry register file.
- Registers MEM-stage results and performs load-data lane extraction with zero/sign extension.
- Drives the register file's single write port (we/waddr/wdata).
- Serialises load-pair (two-destination) results over two cycles, raising a stall request to the upstream pipeline while the second write is pending.

Parameters:
- DATA_W, 64, data/register width.
- ADDR_W, 5, register address width.
- ZR_IDX, 31, index of the zero register. Writes to it are suppressed.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- flush_i  input  1  discard the current and pending write-back.
- mem_valid_i  input  1  MEM stage presents a valid instruction.
- mem_wreg_i  input  1  first destination write requested.
- mem_wd_i  input  ADDR_W  first destination address.
- mem_wdata_i  input  DATA_W  ALU/address result for non-loads.
- mem_is_load_i  input  1  first write takes load data.
- mem_ld_size_i  input  2  load size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- mem_ld_signed_i  input  1  sign-extend load.
- mem_addr_lo_i  input  3  low bits of the load address.
- mem_rdata_i  input  DATA_W  raw 64-bit data-memory read word.
- mem_wreg2_i  input  1  second destination (pair) requested.
- mem_wd2_i  input  ADDR_W  second destination address.
- mem_wdata2_i  input  DATA_W  second write data, already extended by MEM.
- stallreq_o  output  1  upstream must hold the MEM stage.
- we  output  1  register-file write enable.
- waddr  output  ADDR_W  register-file write address.
- wdata  output  DATA_W  register-file write data.
- wb_cnt_o  output  32  committed-write counter (optional feature).

Behaviour:

*Reset*
- Synchronous active-high: on a posedge with rst=1, we=0, waddr=0, wdata=0, state=IDLE, pending registers=0, wb_cnt_o=0.
- Reset mid-pair drops the second write.

*FSM states:* IDLE, PAIR.
- stallreq_o = (state==PAIR), combinational from state only.

*IDLE*
- On a posedge with mem_valid_i=1 and flush_i=0:
  - we <= mem_wreg_i && (mem_wd_i != ZR_IDX).
  - waddr <= mem_wd_i.
  - wdata <= extracted load data if mem_is_load_i, else mem_wdata_i.
- If mem_wreg2_i=1: latch mem_wd2_i and mem_wdata2_i into the pending registers; state <= PAIR.
- If mem_valid_i=0: we <= 0, waddr/wdata hold.

*PAIR*
- mem_* inputs are ignored; upstream holds them stable because stallreq_o=1.
- On the next posedge:
  - we <= (pending addr != ZR_IDX).
  - waddr/wdata <= pending values.
  - state <= IDLE.
- The held MEM instruction is accepted in the following IDLE cycle.

*Latency*
- Write-back outputs are valid one cycle after MEM presents; the register file commits on the next posedge.
- Pair: first write at T+1, second at T+2. Exactly one stall cycle is visible upstream.

*Load extraction*
- Byte: lane = mem_addr_lo_i.
- Half: lane = mem_addr_lo_i[2:1].
- Word: lane = mem_addr_lo_i[2].
- Dword: whole word; address bits ignored.
- Address bits below the access size are ignored; there is no misalignment fault here.
- Zero-extend to DATA_W, or sign-extend from the field MSB when mem_ld_signed_i=1.

*Flush*
- On a posedge with flush_i=1 (rst=0): we <= 0, state <= IDLE, pending write discarded, stallreq_o drops next cycle.
- flush_i has priority over mem_valid_i.

*Boundary cases*
- Both pair destinations equal: two sequential writes, second value wins.
- Destination ZR_IDX: we=0, counter unchanged. The other pair half is still written.

Optional Feature:
- Macro WB_STAGE_PERF_CNT_EN.
- Defined: wb_cnt_o is a 32-bit counter incrementing on every posedge where we is asserted in the output register, i.e. each committed write. It wraps from 0xFFFFFFFF to 0 and clears on rst.
- Undefined: wb_cnt_o is tied to 0 and no counter flops are built. The port list is unchanged in both cases.

Decomposition:
- Shared defines file holds:
  - register/data bus widths and the zero-register index;
  - load-size encodings LD_B/LD_H/LD_W/LD_D;
  - FSM state encodings WB_IDLE/WB_PAIR;
  - the RstEnable/WriteEnable constants already used by the datapath.
- One combinational sub-module, ld_extract (size, signed, addr_lo, rdata -> extended data), reused by any future MEM-side alignment logic.

Test Plan:
1. ldrsb: size=0, signed=1, addr_lo=5, rdata=0x0000_80FF_0000_0000, wd=3 -> next cycle we=1, waddr=3, wdata=0xFFFF_FFFF_FFFF_FF80. Repeat with signed=0 -> wdata=0x80.
2. ldp to x4/x5 with wdata=0x11 and wdata2=0x22 -> T+1: we=1, waddr=4, wdata=0x11, stallreq_o=1. T+2: waddr=5, wdata=0x22, stallreq_o=0. Next held instruction is written at T+3.
3. ALU result to x31 -> we=0. ldp x31/x6 -> only the x6 write asserts we; wb_cnt_o increments by 1.
4. flush_i during PAIR -> second write never appears (we=0), state IDLE, stallreq_o=0 the next cycle.
5. rst=1 asserted in the PAIR cycle -> next posedge: all outputs 0, stallreq_o=0, counter 0. rst held with mem_valid_i=1 -> no writes.
6. ldrh, addr_lo=6, rdata=0xBEEF_0000_0000_0000, unsigned -> wdata=0xBEEF. Same with size=3 -> wdata equals rdata.
